// File: rtl/crossbar_pkg.sv
// Shared types for the 2-master crossbar: master IDs, one-hot grants and
// the grant-to-ID decode used by the response router.
package crossbar_pkg;

  localparam int MST_NUM = 2;

  typedef logic [0:0]         mst_id_t;
  typedef logic [MST_NUM-1:0] grnt_t;

  typedef struct packed {
    logic    vld;
    mst_id_t id;
  } id_dec_t;

  // Only 01 and 10 are legal grants; 00 and 11 decode as invalid.
  function automatic id_dec_t onehot2id(input grnt_t g);
    id_dec_t r;
    r.vld = (g == 2'b01) || (g == 2'b10);
    r.id  = mst_id_t'(g[1]);
    return r;
  endfunction

endpackage

// File: rtl/resp_id_fifo.sv
// Synchronous FIFO of master IDs recording the owner of every outstanding
// request, in acceptance order.
module resp_id_fifo
  import crossbar_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push_i,
  input  mst_id_t       id_i,
  input  logic          pop_i,
  output mst_id_t       head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  mst_id_t       mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= id_i;
  end

endmodule

// File: rtl/resp_router.sv
// Return path for one slave port: steers each slave response to the master
// that issued the matching request, in order, and flags protocol errors.
module resp_router
  import crossbar_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        cmd_fire,
  input  logic [1:0]                  cmd_grnt,
  output logic                        cmd_ready,
  input  logic                        s_resp_valid,
  input  logic [DATA_W-1:0]           s_resp_data,
  output logic                        s_resp_ready,
  output logic [1:0]                  m_resp_valid,
  output logic [2*DATA_W-1:0]         m_resp_data,
  input  logic [1:0]                  m_resp_ready,
  output logic [$clog2(DEPTH):0]      outstanding,
  output logic                        err_bad_grnt,
  output logic                        err_unexp
);

  id_dec_t dec;
  mst_id_t head;
  logic    full, empty, push, pop;
  logic    err_bad_q, err_bad_d, err_unexp_q, err_unexp_d;

  assign dec       = onehot2id(grnt_t'(cmd_grnt));
  assign push      = cmd_fire && dec.vld;
  assign cmd_ready = !full;
  assign pop       = s_resp_valid && s_resp_ready && !empty;

  resp_id_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .id_i    (dec.id),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding)
  );

  // With nothing outstanding, responses are swallowed so the slave never stalls.
  always_comb begin
    m_resp_valid = 2'b00;
    s_resp_ready = 1'b1;
    if (!empty) begin
      m_resp_valid[head] = s_resp_valid;
      s_resp_ready       = m_resp_ready[head];
    end
  end

  assign m_resp_data = {2{s_resp_data}};

  assign err_bad_d   = err_bad_q   || (cmd_fire && !dec.vld);
  assign err_unexp_d = err_unexp_q || (s_resp_valid && empty);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_bad_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      err_bad_q   <= err_bad_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  assign err_bad_grnt = err_bad_q;
  assign err_unexp    = err_unexp_q;

endmodule

// File: tb/tb_resp_router.sv
// Directed testbench for resp_router (DATA_W=32, DEPTH=4).
module tb_resp_router;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              cmd_fire;
  logic [1:0]        cmd_grnt;
  logic              cmd_ready;
  logic              s_resp_valid;
  logic [DATA_W-1:0] s_resp_data;
  logic              s_resp_ready;
  logic [1:0]        m_resp_valid;
  logic [2*DATA_W-1:0] m_resp_data;
  logic [1:0]        m_resp_ready;
  logic [2:0]        outstanding;
  logic              err_bad_grnt;
  logic              err_unexp;

  int errors = 0;
  int checks = 0;

  resp_router #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cmd_fire     (cmd_fire),
    .cmd_grnt     (cmd_grnt),
    .cmd_ready    (cmd_ready),
    .s_resp_valid (s_resp_valid),
    .s_resp_data  (s_resp_data),
    .s_resp_ready (s_resp_ready),
    .m_resp_valid (m_resp_valid),
    .m_resp_data  (m_resp_data),
    .m_resp_ready (m_resp_ready),
    .outstanding  (outstanding),
    .err_bad_grnt (err_bad_grnt),
    .err_unexp    (err_unexp)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here and
  // checked #3 later, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_fire     = 1'b0;
    cmd_grnt     = 2'b00;
    s_resp_valid = 1'b0;
    s_resp_data  = '0;
    m_resp_ready = 2'b11;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    #3;
    checks++;
    if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    checks++;
    if (cmd_ready !== 1'b1 || s_resp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got cmd=%b s=%b exp=1 1", cmd_ready, s_resp_ready); end
    checks++;
    if (m_resp_valid !== 2'b00 || err_bad_grnt !== 1'b0 || err_unexp !== 1'b0) begin
      errors++; $display("FAIL reset_outs got mv=%b eb=%b eu=%b exp=00 0 0", m_resp_valid, err_bad_grnt, err_unexp);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    tick();
    cmd_fire = 1'b1; cmd_grnt = 2'b01;
    tick();
    cmd_fire = 1'b0; cmd_grnt = 2'b00;
    s_resp_valid = 1'b1; s_resp_data = 32'hA5A5_0001; m_resp_ready = 2'b11;
    #3;
    checks++;
    if (outstanding !== 3'd1) begin errors++; $display("FAIL single_out1 got=%0d exp=1", outstanding); end
    checks++;
    if (m_resp_valid !== 2'b01 || m_resp_data[31:0] !== 32'hA5A5_0001 || s_resp_ready !== 1'b1) begin
      errors++; $display("FAIL single_route got mv=%b d0=%h sr=%b exp=01 a5a50001 1", m_resp_valid, m_resp_data[31:0], s_resp_ready);
    end
    tick();
    s_resp_valid = 1'b0;
    #3;
    checks++;
    if (outstanding !== 3'd0 || err_unexp !== 1'b0) begin errors++; $display("FAIL single_out0 got=%0d eu=%b exp=0 0", outstanding, err_unexp); end
  endtask

  task automatic test_order();
    logic [1:0]  grnts [3];
    logic [31:0] data  [3];
    grnts = '{2'b10, 2'b01, 2'b10};
    data  = '{32'hD000_0000, 32'hD111_1111, 32'hD222_2222};
    for (int i = 0; i < 3; i++) begin
      cmd_fire = 1'b1; cmd_grnt = grnts[i];
      tick();
    end
    cmd_fire = 1'b0; cmd_grnt = 2'b00;
    #3;
    checks++;
    if (outstanding !== 3'd3) begin errors++; $display("FAIL order_peak got=%0d exp=3", outstanding); end
    for (int i = 0; i < 3; i++) begin
      s_resp_valid = 1'b1; s_resp_data = data[i];
      #1;
      checks++;
      if (m_resp_valid !== grnts[i] || m_resp_data[63:32] !== data[i] || m_resp_data[31:0] !== data[i]) begin
        errors++; $display("FAIL order_resp%0d got mv=%b d=%h exp mv=%b d=%h", i, m_resp_valid, m_resp_data, grnts[i], data[i]);
      end
      tick();
    end
    s_resp_valid = 1'b0;
    #3;
    checks++;
    if (outstanding !== 3'd0) begin errors++; $display("FAIL order_drain got=%0d exp=0", outstanding); end
  endtask

  task automatic test_back_to_back();
    cmd_fire = 1'b1; cmd_grnt = 2'b01;
    tick();
    cmd_grnt = 2'b10;
    s_resp_valid = 1'b1; s_resp_data = 32'h0000_00B0;
    #3;
    checks++;
    if (m_resp_valid !== 2'b01) begin errors++; $display("FAIL b2b_first got mv=%b exp=01", m_resp_valid); end
    tick();
    cmd_fire = 1'b0; cmd_grnt = 2'b00;
    s_resp_data = 32'h0000_00B1;
    #3;
    checks++;
    if (outstanding !== 3'd1 || m_resp_valid !== 2'b10) begin
      errors++; $display("FAIL b2b_second got out=%0d mv=%b exp=1 10", outstanding, m_resp_valid);
    end
    tick();
    s_resp_valid = 1'b0;
    #3;
    checks++;
    if (outstanding !== 3'd0) begin errors++; $display("FAIL b2b_drain got=%0d exp=0", outstanding); end
  endtask

  task automatic test_full();
    logic [1:0] grnts [4];
    grnts = '{2'b10, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 4; i++) begin
      cmd_fire = 1'b1; cmd_grnt = grnts[i];
      tick();
    end
    cmd_grnt = 2'b10;
    #3;
    checks++;
    if (cmd_ready !== 1'b0 || outstanding !== 3'd4) begin
      errors++; $display("FAIL full_state got rdy=%b out=%0d exp=0 4", cmd_ready, outstanding);
    end
    tick();
    cmd_fire = 1'b0; cmd_grnt = 2'b00;
    s_resp_valid = 1'b1; s_resp_data = 32'hF000_0000;
    #3;
    checks++;
    if (outstanding !== 3'd4 || m_resp_valid !== 2'b10 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL full_fifth got out=%0d mv=%b rdy=%b exp=4 10 0", outstanding, m_resp_valid, cmd_ready);
    end
    tick();
    s_resp_valid = 1'b0;
    #3;
    checks++;
    if (cmd_ready !== 1'b1 || outstanding !== 3'd3) begin
      errors++; $display("FAIL full_release got rdy=%b out=%0d exp=1 3", cmd_ready, outstanding);
    end
    for (int i = 0; i < 3; i++) begin
      s_resp_valid = 1'b1;
      #1;
      checks++;
      if (m_resp_valid !== 2'b01) begin errors++; $display("FAIL full_drain%0d got mv=%b exp=01", i, m_resp_valid); end
      tick();
    end
    s_resp_valid = 1'b0;
    #3;
    checks++;
    if (outstanding !== 3'd0 || err_unexp !== 1'b0 || err_bad_grnt !== 1'b0) begin
      errors++; $display("FAIL full_end got out=%0d eu=%b eb=%b exp=0 0 0", outstanding, err_unexp, err_bad_grnt);
    end
  endtask

  task automatic test_hold();
    cmd_fire = 1'b1; cmd_grnt = 2'b10;
    tick();
    cmd_fire = 1'b0; cmd_grnt = 2'b00;
    s_resp_valid = 1'b1; s_resp_data = 32'h0000_4444; m_resp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++;
      if (s_resp_ready !== 1'b0 || m_resp_valid !== 2'b10 || outstanding !== 3'd1) begin
        errors++; $display("FAIL hold_cyc%0d got sr=%b mv=%b out=%0d exp=0 10 1", i, s_resp_ready, m_resp_valid, outstanding);
      end
      tick();
    end
    m_resp_ready = 2'b11;
    #3;
    checks++;
    if (s_resp_ready !== 1'b1 || m_resp_valid !== 2'b10) begin
      errors++; $display("FAIL hold_release got sr=%b mv=%b exp=1 10", s_resp_ready, m_resp_valid);
    end
    tick();
    s_resp_valid = 1'b0;
    #3;
    checks++;
    if (outstanding !== 3'd0) begin errors++; $display("FAIL hold_pop got=%0d exp=0", outstanding); end
  endtask

  task automatic test_errors();
    cmd_fire = 1'b1; cmd_grnt = 2'b11;
    tick();
    cmd_fire = 1'b0; cmd_grnt = 2'b00;
    #3;
    checks++;
    if (err_bad_grnt !== 1'b1 || outstanding !== 3'd0 || err_unexp !== 1'b0) begin
      errors++; $display("FAIL err_bad got eb=%b out=%0d eu=%b exp=1 0 0", err_bad_grnt, outstanding, err_unexp);
    end
    tick();
    s_resp_valid = 1'b1; s_resp_data = 32'hDEAD_BEEF; m_resp_ready = 2'b00;
    #3;
    checks++;
    if (s_resp_ready !== 1'b1 || m_resp_valid !== 2'b00) begin
      errors++; $display("FAIL err_empty_drain got sr=%b mv=%b exp=1 00", s_resp_ready, m_resp_valid);
    end
    tick();
    s_resp_valid = 1'b0; m_resp_ready = 2'b11;
    #3;
    checks++;
    if (err_unexp !== 1'b1) begin errors++; $display("FAIL err_unexp got=%b exp=1", err_unexp); end
    tick();
    tick();
    #3;
    checks++;
    if (err_bad_grnt !== 1'b1 || err_unexp !== 1'b1) begin
      errors++; $display("FAIL err_sticky got eb=%b eu=%b exp=1 1", err_bad_grnt, err_unexp);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cmd_fire = 1'b1; cmd_grnt = (i == 1) ? 2'b01 : 2'b10;
      tick();
    end
    cmd_fire = 1'b0; cmd_grnt = 2'b11;
    #3;
    checks++;
    if (outstanding !== 3'd3) begin errors++; $display("FAIL rmid_pre got=%0d exp=3", outstanding); end
    cmd_grnt = 2'b00;
    resetn = 1'b0;
    #1;
    checks++;
    if (outstanding !== 3'd0 || cmd_ready !== 1'b1 || err_bad_grnt !== 1'b0 || err_unexp !== 1'b0) begin
      errors++; $display("FAIL rmid_flush got out=%0d rdy=%b eb=%b eu=%b exp=0 1 0 0", outstanding, cmd_ready, err_bad_grnt, err_unexp);
    end
    tick();
    resetn = 1'b1;
    tick();
    s_resp_valid = 1'b1; s_resp_data = 32'h1234_5678;
    #3;
    checks++;
    if (m_resp_valid !== 2'b00 || s_resp_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_drop got mv=%b sr=%b exp=00 1", m_resp_valid, s_resp_ready);
    end
    tick();
    s_resp_valid = 1'b0;
    #3;
    checks++;
    if (err_unexp !== 1'b1) begin errors++; $display("FAIL rmid_unexp got=%b exp=1", err_unexp); end
  endtask

  initial begin
    resetn = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_order();
    test_back_to_back();
    test_full();
    test_hold();
    test_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
